// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of the async FIFO: write-pointer crossing, memory read port,
// output handshake and status.
//   master : the read controller (drives rptr_gray, raddr, dout, dout_valid, empty, level)
//   slave  : the surrounding system (drives wptr_gray, rdata_mem, dout_ready)
interface fifo_read_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata_mem;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  empty;
  logic [ADDR_WIDTH:0]   level;

  modport master (
    input  wptr_gray, rdata_mem, dout_ready,
    output rptr_gray, raddr, dout, dout_valid, empty, level
  );

  modport slave (
    output wptr_gray, rdata_mem, dout_ready,
    input  rptr_gray, raddr, dout, dout_valid, empty, level
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read-domain controller of the asynchronous FIFO.
// Synchronizes the Gray write pointer, derives empty/level, advances the read
// pointer and feeds a one-entry registered output stage with valid/ready.
// Ports:
//   rclk   : read-domain clock
//   rrst_n : asynchronous active-low reset
//   bus    : fifo_read_ctrl_if.master (pointers, memory read port, handshake, status)
module fifo_read_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic               rclk,
  input logic               rrst_n,
  fifo_read_ctrl_if.master  bus
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         rbin;
  logic [PW-1:0]         rgray;
  logic [PW-1:0]         wq1;
  logic [PW-1:0]         wq2;
  logic [PW-1:0]         rbin_inc;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  empty_c;
  logic                  pop_c;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = 1; i < int'(PW); i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Two-flop crossing of the write pointer.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= bus.wptr_gray;
      wq2 <= wq1;
    end
  end

  // Pop whenever memory has a word and the output stage is free or being drained.
  always_comb begin
    rbin_inc = rbin + PW'(1);
    empty_c  = (rgray == wq2);
    pop_c    = !empty_c && (!dout_valid_q || bus.dout_ready);
  end

  // Read pointer and output stage.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin         <= '0;
      rgray        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (pop_c) begin
      rbin         <= rbin_inc;
      rgray        <= rbin_inc ^ (rbin_inc >> 1);
      dout_q       <= bus.rdata_mem;
      dout_valid_q <= 1'b1;
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign bus.rptr_gray  = rgray;
  assign bus.raddr      = rbin[ADDR_WIDTH-1:0];
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.empty      = empty_c;
  // Modulo subtraction; the extra pointer bit makes a full memory read as 2^ADDR_WIDTH.
  assign bus.level      = gray2bin(wq2) - rbin;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: the bench acts as write side and
// memory, a scoreboard queue holds words in write order, and a monitor
// compares every word accepted by the consumer.
module tb_fifo_read_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1 << AW;

  logic rclk;
  logic rrst_n;

  fifo_read_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fifo_read_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  assign bus.rdata_mem = mem[bus.raddr];

  logic [DW-1:0] exp_q [$];
  int            n_vec;
  int            n_err;
  int            n_acc;
  logic [AW:0]   wcount;
  logic [AW:0]   prev_rptr;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Reference conversions written bitwise, independent of the design.
  function automatic logic [AW:0] to_gray(input logic [AW:0] b);
    logic [AW:0] g;
    for (int i = 0; i < int'(AW); i++) g[i] = b[i] ^ b[i+1];
    g[AW] = b[AW];
    return g;
  endfunction

  function automatic logic [AW:0] from_gray(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = int'(AW) - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Write one word: memory first, then the Gray pointer, as a real write side would.
  task automatic push(input logic [DW-1:0] d);
    mem[wcount[AW-1:0]] = d;
    exp_q.push_back(d);
    wcount = wcount + 1'b1;
    bus.wptr_gray = to_gray(wcount);
  endtask

  function automatic logic wr_full();
    logic [AW:0] occ;
    occ = wcount - from_gray(bus.rptr_gray);
    return occ == (AW+1)'(DEPTH);
  endfunction

  // Mid-cycle asynchronous reset of both sides; optionally check outputs at once.
  task automatic do_reset(input bit check);
    @(posedge rclk);
    #2;
    rrst_n = 1'b0;
    #1;
    if (check) begin
      chk("rst_dout_valid", 64'(bus.dout_valid), 64'd0);
      chk("rst_empty",      64'(bus.empty),      64'd1);
      chk("rst_rptr_gray",  64'(bus.rptr_gray),  64'd0);
      chk("rst_raddr",      64'(bus.raddr),      64'd0);
      chk("rst_dout",       64'(bus.dout),       64'd0);
      chk("rst_level",      64'(bus.level),      64'd0);
    end
    exp_q.delete();
    wcount         = '0;
    bus.wptr_gray  = '0;
    bus.dout_ready = 1'b0;
    n_acc          = 0;
    @(posedge rclk);
    #2;
    rrst_n = 1'b1;
  endtask

  // Scoreboard monitor: a word is consumed on the edge after valid&&ready is seen.
  always @(negedge rclk) begin
    if (rrst_n && bus.dout_valid && bus.dout_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h expected none", bus.dout);
      end else begin
        chk("dout_word", 64'(bus.dout), 64'(exp_q.pop_front()));
      end
    end
  end

  // Every change of the exported read pointer must flip exactly one bit.
  always @(negedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      prev_rptr <= '0;
    end else begin
      if (bus.rptr_gray != prev_rptr)
        chk("rptr_one_bit", 64'($countones(bus.rptr_gray ^ prev_rptr)), 64'd1);
      prev_rptr <= bus.rptr_gray;
    end
  end

  initial begin
    int            pops;
    int            wraps;
    int            gaps;
    int            bound;
    logic [AW:0]   last_r;
    logic [AW-1:0] last_a;
    logic [DW-1:0] held;
    bit            seen;

    n_vec = 0; n_err = 0; n_acc = 0;
    wcount = '0;
    bus.wptr_gray = '0;
    bus.dout_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h1111_0000 + DW'(i);
    rrst_n = 1'b0;
    #12;
    rrst_n = 1'b1;

    // Reset with a stale write pointer and a loaded output stage.
    tick(); tick();
    bus.wptr_gray = 5'b00011;
    exp_q.push_back(mem[0]);
    repeat (4) tick();
    do_reset(1'b1);
    repeat (3) begin
      tick();
      chk("post_rst_level", 64'(bus.level), 64'd0);
    end

    // Single word latency.
    tick();
    bus.dout_ready = 1'b1;
    mem[0] = 32'hA5A5_0001;
    push(32'hA5A5_0001);
    tick(); chk("sw_empty_e1", 64'(bus.empty), 64'd1);
    tick(); chk("sw_empty_e2", 64'(bus.empty), 64'd0);
            chk("sw_valid_e2", 64'(bus.dout_valid), 64'd0);
    tick(); chk("sw_valid_e3", 64'(bus.dout_valid), 64'd1);
            chk("sw_dout_e3",  64'(bus.dout), 64'hA5A5_0001);
    tick(); chk("sw_valid_e4", 64'(bus.dout_valid), 64'd0);

    // Streaming 40 words through two address wraps.
    do_reset(1'b0);
    bus.dout_ready = 1'b1;
    pops = 0; wraps = 0; gaps = 0; seen = 1'b0;
    last_r = bus.rptr_gray; last_a = bus.raddr;
    for (int c = 0; c < 60; c++) begin
      if (c < 40) push(DW'(c));
      tick();
      if (bus.rptr_gray != last_r) begin
        pops++;
        if (pops == 8) chk("stream_rptr_8", 64'(bus.rptr_gray), 64'b01100);
      end
      if (last_a == AW'(DEPTH - 1) && bus.raddr == '0) wraps++;
      if (bus.dout_valid) seen = 1'b1;
      else if (seen && n_acc < 40) gaps++;
      last_r = bus.rptr_gray; last_a = bus.raddr;
    end
    chk("stream_count", 64'(n_acc), 64'd40);
    chk("stream_wraps", 64'(wraps), 64'd2);
    chk("stream_gaps",  64'(gaps),  64'd0);

    // Backpressure: four words, consumer stalled.
    do_reset(1'b0);
    pops = 0;
    last_r = bus.rptr_gray;
    for (int c = 0; c < 14; c++) begin
      if (c < 4) push(32'hB000_0000 + DW'(c));
      tick();
      if (bus.rptr_gray != last_r) pops++;
      last_r = bus.rptr_gray;
      if (c == 4) held = bus.dout;
    end
    chk("bp_pops",   64'(pops),           64'd1);
    chk("bp_valid",  64'(bus.dout_valid), 64'd1);
    chk("bp_dout",   64'(bus.dout),       64'hB000_0000);
    chk("bp_stable", 64'(bus.dout),       64'(held));
    chk("bp_raddr",  64'(bus.raddr),      64'd1);
    chk("bp_level",  64'(bus.level),      64'd3);
    bus.dout_ready = 1'b1;
    repeat (4) tick();
    chk("bp_drain_cnt", 64'(n_acc),     64'd4);
    chk("bp_empty",     64'(bus.empty), 64'd1);

    // Full occupancy: pointer placed at 16 in one step while stalled.
    do_reset(1'b0);
    tick();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i] = 32'hC000_0000 + DW'(i);
      exp_q.push_back(mem[i]);
    end
    wcount = (AW+1)'(DEPTH);
    bus.wptr_gray = to_gray(wcount);
    tick(); chk("full_empty_e1", 64'(bus.empty), 64'd1);
            chk("full_level_e1", 64'(bus.level), 64'd0);
    tick(); chk("full_level_e2", 64'(bus.level), 64'd16);
            chk("full_valid_e2", 64'(bus.dout_valid), 64'd0);
    tick(); chk("full_level_e3", 64'(bus.level), 64'd15);
            chk("full_valid_e3", 64'(bus.dout_valid), 64'd1);
    bus.dout_ready = 1'b1;
    bound = 0;
    while (n_acc < 16 && bound < 40) begin tick(); bound++; end
    chk("full_drained", 64'(n_acc), 64'd16);
    tick();
    chk("full_empty_end", 64'(bus.empty),     64'd1);
    chk("full_rptr_end",  64'(bus.rptr_gray), 64'b11000);
    chk("full_level_end", 64'(bus.level),     64'd0);

    // Reset in the middle of a 10-word burst.
    do_reset(1'b0);
    bus.dout_ready = 1'b1;
    bound = 0;
    while (n_acc < 5 && bound < 40) begin
      if (wcount < 10) push(32'hD000_0000 + DW'(wcount));
      tick();
      bound++;
    end
    chk("mb_progress", 64'(n_acc), 64'd5);
    do_reset(1'b1);
    tick();
    chk("mb_raddr_rel", 64'(bus.raddr), 64'd0);
    bus.dout_ready = 1'b1;
    push(32'hDEAD_BEEF);
    bound = 0;
    while (n_acc < 1 && bound < 10) begin tick(); bound++; end
    chk("mb_first_word", 64'(n_acc), 64'd1);

    // Randomized traffic with random consumer stalls.
    do_reset(1'b0);
    for (int c = 0; c < 400; c++) begin
      bus.dout_ready = ($urandom_range(3) != 0);
      if ($urandom_range(2) != 0 && !wr_full()) push($urandom());
      tick();
    end
    bus.dout_ready = 1'b1;
    bound = 0;
    while (exp_q.size() != 0 && bound < 100) begin tick(); bound++; end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
    tick();
    chk("rand_empty",      64'(bus.empty),      64'd1);
    chk("rand_valid_idle", 64'(bus.dout_valid), 64'd0);
    chk("rand_rptr",       64'(bus.rptr_gray),  64'(to_gray(wcount)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl.md
# fifo_read_ctrl

Read-side controller for the asynchronous FIFO. It runs entirely in the read clock domain and drives `raddr` into the FIFO memory array, whose read port is combinational. It brings the write domain's Gray-coded write pointer across the clock boundary, generates `empty` and an occupancy count, and presents data through a one-entry registered output stage with a valid/ready handshake. It also exports its own Gray read pointer so the write-side controller can generate `full`.

## Interface
- `ADDR_WIDTH`, 4: memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `DATA_WIDTH`, 32: data word width.

- `rclk`  in  1  read-domain clock; all state updates on its rising edge.
- `rrst_n`  in  1  reset, asynchronous assert, active-low.
- `wptr_gray`  in  ADDR_WIDTH+1  write pointer, Gray-coded, from the write domain; asynchronous to `rclk`.
- `rptr_gray`  out  ADDR_WIDTH+1  read pointer, Gray-coded, driven directly from a flop; goes to the write domain.
- `raddr`  out  ADDR_WIDTH  memory read address, equal to `rbin[ADDR_WIDTH-1:0]`.
- `rdata_mem`  in  DATA_WIDTH  memory read data, combinational from `raddr`.
- `dout`  out  DATA_WIDTH  output data register.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `empty`  out  1  no word left in memory; the output register is not counted.
- `level`  out  ADDR_WIDTH+1  words in memory, not counting the output register; range 0..2^ADDR_WIDTH.

## Operation
- **Internal state**
  - `rbin`: binary read pointer, ADDR_WIDTH+1 bits.
  - `rptr_gray`: Gray read pointer.
  - `wq1`, `wq2`: two-flop synchronizer for `wptr_gray`.
  - `dout`, `dout_valid`: output stage.
- **Synchronizer:** each cycle `wq1 <= wptr_gray`, then `wq2 <= wq1`. No other logic reads `wq1`.
- **Empty:** `empty = (rptr_gray == wq2)`. This is a pure compare of flop outputs.
- **Level:** `level = gray2bin(wq2) - rbin`, modulo 2^(ADDR_WIDTH+1).
- **Pop condition:** `pop = !empty && (!dout_valid || dout_ready)`.
- **When pop is true:**
  - `dout <= rdata_mem`
  - `dout_valid <= 1`
  - `rbin <= rbin + 1`
  - `rptr_gray <= (rbin+1) ^ ((rbin+1) >> 1)`
- **When pop is false and `dout_valid && dout_ready`:** `dout_valid <= 0`. `dout` keeps its last value.
- **Otherwise:** all state holds.
- **Pointer wrap:** `rbin` wraps from 2^(ADDR_WIDTH+1)-1 to 0, and `raddr` wraps from 2^ADDR_WIDTH-1 to 0. The extra MSB lets the write side tell full from empty. No special case is needed at wrap.
- **Simultaneous consume and pop:** `dout` is replaced with the next word and `dout_valid` stays 1. There is no bubble.
- **Backpressure:** while `dout_valid && !dout_ready`, `dout` is stable and the pointers do not advance.
- **Reset (`rrst_n` low, asynchronous):**
  - `rbin=0`, `rptr_gray=0`, `wq1=wq2=0`, `dout=0`, `dout_valid=0`.
  - This gives `empty=1`, `level=0`, `raddr=0`.
  - Reset during a transfer discards the output word and any unread memory contents as seen by this side. The write side must be reset in the same system reset.

## Timing
- **Synchronizer latency:** a change on `wptr_gray` that is stable before rclk edge E1 reaches `wq2` after edge E2.
- **First word latency:** `empty` falls after E2. Pop happens at E3, so `dout_valid=1` after E3.
- **Throughput:** one word per cycle while `dout_ready=1` and `empty=0`.
- **Pointer export:** `rptr_gray` updates on the same edge as the pop. Exactly one bit changes per pop.
- **Crossing safety:** `wptr_gray` must itself be a Gray-coded, flop-driven signal. Only the single-bit-change property makes the two-flop crossing safe.
- **No combinational paths:** there is none from `dout_ready` to `dout_valid`. `pop` depends combinationally on `dout_ready`, but only registers consume it.

## Test plan
- **Reset:** assert `rrst_n=0` mid-clock with `wptr_gray=5'b00011`.
  - Required immediately, without waiting for a clock: `dout_valid=0`, `empty=1`, `rptr_gray=0`, `raddr=0`, `dout=0`.
  - Level is 0 until the synchronizer refills after release.
- **Single word:** model memory with `mem[0]=32'hA5A5_0001`, hold `dout_ready=1`, step `wptr_gray` 0→1.
  - `empty` falls after the 2nd rclk edge.
  - `dout_valid=1` with `dout=32'hA5A5_0001` after the 3rd edge.
  - `dout_valid` is back to 0 one cycle later.
- **Streaming with wrap:** write 40 words of value i, stepping `wptr_gray` one per cycle in Gray order, with `dout_ready=1`.
  - Reads come out in order 0..39 with no gaps after the first.
  - `raddr` wraps 15→0 twice.
  - `rptr_gray` after the 8th pop is `5'b01100`.
- **Backpressure:** preload 4 words, hold `dout_ready=0` for 10 cycles.
  - Exactly one pop occurs, then `dout` is stable.
  - `rbin=1`, `level=3`.
  - Release `dout_ready`: the remaining 3 words come out back-to-back.
- **Full occupancy:** preload 16 words (`wptr_gray` Gray of 16 = `5'b11000`) with `dout_ready=0`.
  - Before the first pop `level=16`; after it `level=15`.
  - Drain all: `empty=1` and `rptr_gray=5'b11000`.
- **Reset mid-burst:** pulse `rrst_n` low after 5 of 10 words have been read.
  - All outputs return to reset values immediately.
  - With the write side also reset, the next word written appears at `raddr=0`.
